// File: rtl/gmem_axi_slave_mem.sv
// AXI4 full slave backed by a word-addressed on-chip RAM; independent read and write burst engines.
// Define GMEM_SLAVE_STALL_EN to gate the readys and RVALID with a free-running LFSR.
module gmem_axi_slave_mem #(
    parameter int unsigned C_ADDR_WIDTH = 64,
    parameter int unsigned C_DATA_WIDTH = 32,
    parameter int unsigned C_ID_WIDTH   = 1,
    parameter int unsigned C_MEM_WORDS  = 1024
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst_n,
    input  logic                      s_axi_gmem_AWVALID,
    output logic                      s_axi_gmem_AWREADY,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_gmem_AWADDR,
    input  logic [C_ID_WIDTH-1:0]     s_axi_gmem_AWID,
    input  logic [7:0]                s_axi_gmem_AWLEN,
    input  logic                      s_axi_gmem_WVALID,
    output logic                      s_axi_gmem_WREADY,
    input  logic [C_DATA_WIDTH-1:0]   s_axi_gmem_WDATA,
    input  logic [C_DATA_WIDTH/8-1:0] s_axi_gmem_WSTRB,
    input  logic                      s_axi_gmem_WLAST,
    output logic                      s_axi_gmem_BVALID,
    input  logic                      s_axi_gmem_BREADY,
    output logic [1:0]                s_axi_gmem_BRESP,
    output logic [C_ID_WIDTH-1:0]     s_axi_gmem_BID,
    input  logic                      s_axi_gmem_ARVALID,
    output logic                      s_axi_gmem_ARREADY,
    input  logic [C_ADDR_WIDTH-1:0]   s_axi_gmem_ARADDR,
    input  logic [C_ID_WIDTH-1:0]     s_axi_gmem_ARID,
    input  logic [7:0]                s_axi_gmem_ARLEN,
    output logic                      s_axi_gmem_RVALID,
    input  logic                      s_axi_gmem_RREADY,
    output logic [C_DATA_WIDTH-1:0]   s_axi_gmem_RDATA,
    output logic                      s_axi_gmem_RLAST,
    output logic [C_ID_WIDTH-1:0]     s_axi_gmem_RID,
    output logic [1:0]                s_axi_gmem_RRESP
);

    localparam int unsigned StrbW = C_DATA_WIDTH / 8;
    localparam int unsigned Shift = $clog2(StrbW);
    // One spare bit so a burst running past the top of the address space never wraps.
    localparam int unsigned IdxW  = C_ADDR_WIDTH - Shift + 1;
    localparam int unsigned MemAw = $clog2(C_MEM_WORDS);
    localparam logic [IdxW-1:0] MemWords = IdxW'(C_MEM_WORDS);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    typedef enum logic [1:0] {StWIdle, StWData, StWResp} w_state_e;
    typedef enum logic {StRIdle, StRData} r_state_e;

    logic [C_DATA_WIDTH-1:0] mem [C_MEM_WORDS];

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic stall_aw, stall_w, stall_ar, rd_go;

`ifdef GMEM_SLAVE_STALL_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            lfsr_q <= 16'hACE1;
        end else begin
            lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
        end
    end

    assign stall_aw = lfsr_q[0];
    assign stall_w  = lfsr_q[1];
    assign stall_ar = lfsr_q[2];
    assign rd_go    = lfsr_q[3];
`else
    assign stall_aw = 1'b1;
    assign stall_w  = 1'b1;
    assign stall_ar = 1'b1;
    assign rd_go    = 1'b1;
`endif

    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_gmem_AWADDR[Shift-1:0], s_axi_gmem_ARADDR[Shift-1:0]};

    // ---------------------------------------------------------------- write path
    logic [IdxW-1:0]       wr_idx_q;
    logic [7:0]            wr_cnt_q, wr_len_q;
    logic                  wr_err_q;
    logic [1:0]            bresp_q;
    logic [C_ID_WIDTH-1:0] bid_q;
    logic                  aw_hs, w_hs, wr_last, wr_oob, wr_beat_err;
    logic [IdxW-1:0]       aw_word;

    assign s_axi_gmem_AWREADY = (w_state_q == StWIdle) && stall_aw;
    assign s_axi_gmem_WREADY  = (w_state_q == StWData) && stall_w;
    assign s_axi_gmem_BVALID  = (w_state_q == StWResp);
    assign s_axi_gmem_BRESP   = bresp_q;
    assign s_axi_gmem_BID     = bid_q;

    assign aw_hs       = s_axi_gmem_AWVALID && s_axi_gmem_AWREADY;
    assign w_hs        = s_axi_gmem_WVALID && s_axi_gmem_WREADY;
    assign aw_word     = {1'b0, s_axi_gmem_AWADDR[C_ADDR_WIDTH-1:Shift]};
    assign wr_last     = (wr_cnt_q == wr_len_q);
    assign wr_oob      = (wr_idx_q >= MemWords);
    // Beat count ends the burst; a WLAST in the wrong place only poisons the response.
    assign wr_beat_err = wr_oob || (s_axi_gmem_WLAST != wr_last);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_state_q <= StWIdle;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        unique case (w_state_q)
            StWIdle: if (aw_hs) w_state_d = StWData;
            StWData: if (w_hs && wr_last) w_state_d = StWResp;
            StWResp: if (s_axi_gmem_BREADY) w_state_d = StWIdle;
            default: w_state_d = StWIdle;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            wr_idx_q <= '0;
            wr_cnt_q <= '0;
            wr_len_q <= '0;
            wr_err_q <= 1'b0;
            bresp_q  <= RespOkay;
            bid_q    <= '0;
        end else begin
            if (aw_hs) begin
                wr_idx_q <= aw_word;
                wr_cnt_q <= '0;
                wr_len_q <= s_axi_gmem_AWLEN;
                wr_err_q <= 1'b0;
                bid_q    <= s_axi_gmem_AWID;
            end
            if (w_hs) begin
                wr_idx_q <= wr_idx_q + IdxW'(1);
                wr_cnt_q <= wr_cnt_q + 8'd1;
                wr_err_q <= wr_err_q || wr_beat_err;
                if (wr_last) begin
                    bresp_q <= (wr_err_q || wr_beat_err) ? RespSlvErr : RespOkay;
                end
            end
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_hs && !wr_oob) begin
            for (int b = 0; b < StrbW; b++) begin
                if (s_axi_gmem_WSTRB[b]) begin
                    mem[wr_idx_q[MemAw-1:0]][b*8 +: 8] <= s_axi_gmem_WDATA[b*8 +: 8];
                end
            end
        end
    end

    // ----------------------------------------------------------------- read path
    logic [IdxW-1:0]         rd_idx_q;
    logic [7:0]              rd_cnt_q, rd_len_q;
    logic                    rvalid_q, rlast_q, rpend_q;
    logic [C_DATA_WIDTH-1:0] rdata_q;
    logic [1:0]              rresp_q;
    logic [C_ID_WIDTH-1:0]   rid_q;
    logic                    ar_hs, r_hs, rd_fetch, rd_fetch_oob;
    logic [IdxW-1:0]         rd_fetch_idx;
    logic [7:0]              rd_fetch_cnt, rd_fetch_len;

    assign s_axi_gmem_ARREADY = (r_state_q == StRIdle) && stall_ar;
    assign s_axi_gmem_RVALID  = rvalid_q;
    assign s_axi_gmem_RDATA   = rdata_q;
    assign s_axi_gmem_RLAST   = rlast_q;
    assign s_axi_gmem_RRESP   = rresp_q;
    assign s_axi_gmem_RID     = rid_q;

    assign ar_hs = s_axi_gmem_ARVALID && s_axi_gmem_ARREADY;
    assign r_hs  = rvalid_q && s_axi_gmem_RREADY;

    // The RAM output register is loaded on the AR handshake and on every non-final R handshake,
    // so beats stream back to back and the word stays put while RREADY is low.
    assign rd_fetch     = ar_hs || (r_hs && !rlast_q);
    assign rd_fetch_idx = ar_hs ? {1'b0, s_axi_gmem_ARADDR[C_ADDR_WIDTH-1:Shift]}
                                : rd_idx_q + IdxW'(1);
    assign rd_fetch_cnt = ar_hs ? 8'd0 : rd_cnt_q + 8'd1;
    assign rd_fetch_len = ar_hs ? s_axi_gmem_ARLEN : rd_len_q;
    assign rd_fetch_oob = (rd_fetch_idx >= MemWords);

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state_q <= StRIdle;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    always_comb begin
        r_state_d = r_state_q;
        unique case (r_state_q)
            StRIdle: if (ar_hs) r_state_d = StRData;
            StRData: if (r_hs && rlast_q) r_state_d = StRIdle;
            default: r_state_d = StRIdle;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_idx_q <= '0;
            rd_cnt_q <= '0;
            rd_len_q <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rpend_q  <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RespOkay;
            rid_q    <= '0;
        end else begin
            if (ar_hs) begin
                rid_q <= s_axi_gmem_ARID;
            end
            if (rd_fetch) begin
                rd_idx_q <= rd_fetch_idx;
                rd_cnt_q <= rd_fetch_cnt;
                rd_len_q <= rd_fetch_len;
                rlast_q  <= (rd_fetch_cnt == rd_fetch_len);
                rdata_q  <= rd_fetch_oob ? '0 : mem[rd_fetch_idx[MemAw-1:0]];
                rresp_q  <= rd_fetch_oob ? RespSlvErr : RespOkay;
                rvalid_q <= rd_go;
                rpend_q  <= !rd_go;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end else if (rpend_q) begin
                rvalid_q <= 1'b1;
                rpend_q  <= 1'b0;
            end
        end
    end

endmodule
